// File: rtl/ucore_main_core.sv
// ucore_main_core: microcoded core with a fixed 32-word ROM, 8x8 register file and single-cycle execute
// Ports: clk (rising-edge clock), aresetn (asynchronous active-low reset).
// State (pc, regs, halted, icount) is internal and observed hierarchically.
module ucore_main_core #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 5
) (
  input logic clk,
  input logic aresetn
);
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_BZ   = 4'h8;
  localparam logic [3:0] OP_BNZ  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] regs [8];
  logic              halted;
  logic [15:0]       icount;
  logic [15:0]       word;
  logic [3:0]        op;
  logic [2:0]        rd;
  logic [DATA_W-1:0] a, b, res;
  logic              we, taken;
  logic [PC_W-1:0]   pc_nxt;
  always_comb begin
    case (pc)
      PC_W'(0): word = 16'h1200;
      PC_W'(1): word = 16'h140A;
      PC_W'(2): word = 16'h1601;
      PC_W'(3): word = 16'h2250;
      PC_W'(4): word = 16'h3498;
      PC_W'(5): word = 16'h9083;
      PC_W'(6): word = 16'hF000;
      default:  word = 16'h0000;
    endcase
  end
  assign op = word[15:12];
  assign rd = word[11:9];
  // r0 is never written, so reading it always yields zero
  assign a  = regs[word[8:6]];
  assign b  = regs[word[5:3]];
  assign res = op == OP_LDI ? DATA_W'(word[7:0]) :
               op == OP_ADD ? a + b :
               op == OP_SUB ? a - b :
               op == OP_AND ? a & b :
               op == OP_OR  ? a | b :
               op == OP_XOR ? a ^ b : a;
  assign we = op >= OP_LDI && op <= OP_MOV && rd != 3'd0;
  // branch condition uses rs1 as read before this cycle's write
  assign taken = op == OP_JMP || (op == OP_BZ && a == '0) || (op == OP_BNZ && a != '0);
  assign pc_nxt = taken ? word[PC_W-1:0] : pc + PC_W'(1);
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pc     <= '0;
      halted <= 1'b0;
      icount <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (!halted) begin
      if (op == OP_HALT) begin
        halted <= 1'b1;
      end else begin
        pc     <= pc_nxt;
        icount <= icount + 16'd1;
        if (we) regs[rd] <= res;
      end
    end
  end
endmodule

// File: tb/tb_ucore_main_core.sv
// tb_ucore_main_core: scoreboard bench comparing the core's architectural state with a closed-form model of the built-in program
module tb_ucore_main_core;
  typedef struct packed {
    logic [4:0]  pc;
    logic [7:0]  r1, r2, r3;
    logic        h;
    logic [15:0] ic;
  } st_t;
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  st_t  q[$];
  int   n = 0;
  int   vectors = 0;
  int   miscompares = 0;
  ucore_main_core dut (.clk(clk), .aresetn(aresetn));
  initial forever #5 clk = ~clk;
  // State after n instructions since reset release, derived from what the program computes:
  // three LDIs, then a 3-instruction loop run 10 times accumulating 10+9+...+1, then HALT.
  function automatic st_t expf(input int n_in);
    st_t s;
    int  k, i, rem;
    s = '0;
    s.ic = 16'(n_in > 33 ? 33 : n_in);
    s.h  = n_in >= 34;
    s.pc = 5'(n_in < 3 ? n_in : 3);
    if (n_in >= 2) s.r2 = 8'd10;
    if (n_in >= 3) s.r3 = 8'd1;
    if (n_in >= 3) begin
      k = n_in - 3;
      if (k > 30) k = 30;
      i = k / 3;
      rem = k % 3;
      s.r1 = 8'(10 * i - i * (i - 1) / 2);
      s.r2 = 8'(10 - i);
      if (rem >= 1) s.r1 = 8'(s.r1 + s.r2);
      if (rem == 2) s.r2 = 8'(s.r2 - 1);
      s.pc = 5'(k == 30 ? 6 : 3 + rem);
    end
    return s;
  endfunction
  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endfunction
  task automatic run(input int k);
    repeat (k) begin
      @(posedge clk);
      n++;
      q.push_back(expf(n));
    end
  endtask
  // asynchronous reset asserted mid-low-phase, optionally held across edges
  task automatic pulse(input int hold);
    @(negedge clk);
    #2 aresetn = 1'b0;
    n = 0;
    q.push_back(expf(0));
    repeat (hold) begin
      @(posedge clk);
      q.push_back(expf(0));
    end
    @(negedge clk);
    #2 aresetn = 1'b1;
  endtask
  initial begin
    st_t e;
    forever begin
      @(negedge clk or negedge aresetn);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        chk("pc", 16'(dut.pc), 16'(e.pc));
        chk("r0", 16'(dut.regs[0]), 16'h0);
        chk("r1", 16'(dut.regs[1]), 16'(e.r1));
        chk("r2", 16'(dut.regs[2]), 16'(e.r2));
        chk("r3", 16'(dut.regs[3]), 16'(e.r3));
        for (int i = 4; i < 8; i++) chk("r4_7", 16'(dut.regs[i]), 16'h0);
        chk("halted", 16'(dut.halted), 16'(e.h));
        chk("icount", dut.icount, e.ic);
      end
    end
  end
  initial begin
    repeat (2) begin
      @(posedge clk);
      q.push_back(expf(0));
    end
    @(negedge clk);
    #2 aresetn = 1'b1;
    run(40);
    run(60);
    pulse(1);
    run(15);
    pulse(0);
    run(40);
    repeat (8) begin
      pulse(int'($urandom_range(0, 2)));
      run(int'($urandom_range(1, 40)));
    end
    pulse(0);
    run(36);
    @(negedge clk);
    #3;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
